// File: rtl/uart_tx_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : uart_tx_if                                                      |
// | Brief    : Request/status bundle between a UART transmitter and its user.  |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
interface uart_tx_if;
  logic       trmt;
  logic [7:0] tx_data;
  logic       TX;
  logic       tx_done;
  logic       busy;
  logic       full;

  modport master (
    output trmt,
    output tx_data,
    input  TX,
    input  tx_done,
    input  busy,
    input  full
  );

  modport slave (
    input  trmt,
    input  tx_data,
    output TX,
    output tx_done,
    output busy,
    output full
  );
endinterface
`default_nettype wire

// File: rtl/uart_tx.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : uart_tx                                                         |
// | Brief    : 8N1 UART transmitter with a one-byte holding register.          |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module uart_tx #(
  parameter int BAUD_DIV = 5208
) (
  input  logic     clk,
  input  logic     rst_n,
  uart_tx_if.slave bus
);

  localparam int              CNT_W       = $clog2(BAUD_DIV);
  localparam logic [CNT_W-1:0] C_BAUD_LAST = CNT_W'(BAUD_DIV - 1);
  localparam logic [3:0]      C_STOP_BIT  = 4'd9;

  localparam logic [0:0] IDLE     = 1'b0;
  localparam logic [0:0] TRANSMIT = 1'b1;

  logic [0:0]       r_state;
  logic [CNT_W-1:0] r_baud;
  logic [3:0]       r_bit_cnt;
  logic [9:0]       r_shift;
  logic [7:0]       r_hold;
  logic             r_full;
  logic             r_done;

  logic             w_shift;
  logic             w_end;

  assign w_shift = (r_state == TRANSMIT) && (r_baud == C_BAUD_LAST);
  assign w_end   = w_shift && (r_bit_cnt == C_STOP_BIT);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_baud    <= '0;
      r_bit_cnt <= '0;
      r_shift   <= '1;
      r_hold    <= '0;
      r_full    <= 1'b0;
      r_done    <= 1'b0;
    end else if (r_state == IDLE) begin
      if (bus.trmt) begin
        r_state   <= TRANSMIT;
        r_shift   <= {1'b1, bus.tx_data, 1'b0};
        r_baud    <= '0;
        r_bit_cnt <= '0;
        r_done    <= 1'b0;
      end
    end else begin
      r_baud <= w_shift ? '0 : r_baud + 1'b1;
      if (w_end) begin
        r_bit_cnt <= '0;
        // The held byte has priority; a simultaneous request refills the holder.
        if (r_full) begin
          r_shift <= {1'b1, r_hold, 1'b0};
          r_full  <= bus.trmt;
          r_done  <= 1'b0;
          if (bus.trmt) begin
            r_hold <= bus.tx_data;
          end
        end else if (bus.trmt) begin
          r_shift <= {1'b1, bus.tx_data, 1'b0};
          r_done  <= 1'b0;
        end else begin
          r_state <= IDLE;
          r_shift <= '1;
          r_done  <= 1'b1;
        end
      end else begin
        if (w_shift) begin
          r_shift   <= {1'b1, r_shift[9:1]};
          r_bit_cnt <= r_bit_cnt + 4'd1;
        end
        if (bus.trmt && !r_full) begin
          r_hold <= bus.tx_data;
          r_full <= 1'b1;
        end
      end
    end
  end

  // The line bit is the low end of the shift register, so TX comes straight off a flop.
  assign bus.TX      = r_shift[0];
  assign bus.tx_done = r_done;
  assign bus.busy    = (r_state == TRANSMIT);
  assign bus.full    = r_full;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx.sv
`default_nettype none
// Directed bench for uart_tx at 16 clocks per bit; expected frames are hand-written
// {stop, data, start} vectors and are compared against TX on every clock.
module tb_uart_tx;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  uart_tx_if u_if ();

  uart_tx #(.BAUD_DIV(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (u_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Request a byte; returns 1 time unit after the accepting edge.
  task automatic send(input logic [7:0] d);
    u_if.trmt    = 1'b1;
    u_if.tx_data = d;
    @(posedge clk);
    #1;
    u_if.trmt = 1'b0;
  endtask

  // Entered 1 unit after the frame's start edge; leaves 1 unit after its last bit clock.
  task automatic expect_frame(input string tag, input logic [9:0] frame);
    for (int k = 0; k < 160; k++) begin
      check($sformatf("%s tx[%0d]", tag, k), {31'd0, u_if.TX}, {31'd0, frame[k/16]});
      if (k == 0 || k == 159) begin
        check($sformatf("%s busy[%0d]", tag, k), {31'd0, u_if.busy}, 32'd1);
        check($sformatf("%s done[%0d]", tag, k), {31'd0, u_if.tx_done}, 32'd0);
      end
      if (k < 159) begin
        @(posedge clk);
        #1;
      end
    end
  endtask

  task automatic check_idle(input string tag, input logic done_exp);
    check({tag, " tx"},   {31'd0, u_if.TX},      32'd1);
    check({tag, " busy"}, {31'd0, u_if.busy},    32'd0);
    check({tag, " full"}, {31'd0, u_if.full},    32'd0);
    check({tag, " done"}, {31'd0, u_if.tx_done}, {31'd0, done_exp});
  endtask

  initial begin
    n_checks     = 0;
    n_fail       = 0;
    rst_n        = 1'b0;
    u_if.trmt    = 1'b0;
    u_if.tx_data = 8'h00;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check_idle("reset", 1'b0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_idle("post reset", 1'b0);

    // Single byte 0xA5: 0,1,0,1,0,0,1,0,1,1
    send(8'hA5);
    expect_frame("a5", 10'b1101001010);
    @(posedge clk);
    #1;
    check_idle("a5 end", 1'b1);
    repeat (5) @(posedge clk);
    #1;
    check({"a5 done hold"}, {31'd0, u_if.tx_done}, 32'd1);

    // Back-to-back 0x55 then 0x0F queued at clock 20
    send(8'h55);
    fork
      begin
        expect_frame("b2b 55", 10'b1010101010);
        @(posedge clk);
        #1;
      end
      begin
        repeat (19) @(posedge clk);
        #1;
        u_if.trmt    = 1'b1;
        u_if.tx_data = 8'h0F;
        @(posedge clk);
        #1;
        u_if.trmt = 1'b0;
        check("b2b full@20", {31'd0, u_if.full}, 32'd1);
        repeat (139) @(posedge clk);
        #1;
        check("b2b full@159", {31'd0, u_if.full}, 32'd1);
      end
    join
    check("b2b full@160", {31'd0, u_if.full}, 32'd0);
    expect_frame("b2b 0f", 10'b1000011110);
    @(posedge clk);
    #1;
    check_idle("b2b end", 1'b1);

    // Overflow: 0x22 held, 0x33 dropped
    send(8'h11);
    fork
      begin
        expect_frame("ovf 11", 10'b1000100010);
        @(posedge clk);
        #1;
      end
      begin
        repeat (29) @(posedge clk);
        #1;
        u_if.trmt    = 1'b1;
        u_if.tx_data = 8'h22;
        @(posedge clk);
        #1;
        u_if.trmt = 1'b0;
        check("ovf full@30", {31'd0, u_if.full}, 32'd1);
        repeat (19) @(posedge clk);
        #1;
        u_if.trmt    = 1'b1;
        u_if.tx_data = 8'h33;
        @(posedge clk);
        #1;
        u_if.trmt = 1'b0;
        check("ovf full@50", {31'd0, u_if.full}, 32'd1);
        repeat (109) @(posedge clk);
        #1;
        check("ovf full@159", {31'd0, u_if.full}, 32'd1);
      end
    join
    check("ovf full@160", {31'd0, u_if.full}, 32'd0);
    expect_frame("ovf 22", 10'b1001000100);
    @(posedge clk);
    #1;
    check_idle("ovf end", 1'b1);

    // Request exactly on the frame-end edge with nothing held
    send(8'h55);
    fork
      begin
        expect_frame("sim 55", 10'b1010101010);
        @(posedge clk);
        #1;
      end
      begin
        repeat (159) @(posedge clk);
        #1;
        u_if.trmt    = 1'b1;
        u_if.tx_data = 8'h3C;
        @(posedge clk);
        #1;
        u_if.trmt = 1'b0;
        check("sim done@160", {31'd0, u_if.tx_done}, 32'd0);
        check("sim full@160", {31'd0, u_if.full},    32'd0);
      end
    join
    expect_frame("sim 3c", 10'b1001111000);
    @(posedge clk);
    #1;
    check_idle("sim end", 1'b1);

    // Reset during data bit 4 of 0xFF with 0x5A held; trmt during reset ignored
    send(8'hFF);
    repeat (9) @(posedge clk);
    #1;
    u_if.trmt    = 1'b1;
    u_if.tx_data = 8'h5A;
    @(posedge clk);
    #1;
    u_if.trmt = 1'b0;
    check("rst full held", {31'd0, u_if.full}, 32'd1);
    repeat (74) @(posedge clk);
    #1;
    check("rst tx bit4", {31'd0, u_if.TX},   32'd1);
    check("rst busy",    {31'd0, u_if.busy}, 32'd1);
    rst_n        = 1'b0;
    u_if.trmt    = 1'b1;
    u_if.tx_data = 8'h77;
    @(posedge clk);
    #1;
    rst_n     = 1'b1;
    u_if.trmt = 1'b0;
    check_idle("rst edge", 1'b0);
    repeat (200) @(posedge clk);
    #1;
    check_idle("rst quiet", 1'b0);
    send(8'h81);
    expect_frame("rst 81", 10'b1100000010);
    @(posedge clk);
    #1;
    check_idle("rst 81 end", 1'b1);

    // Three bytes back-to-back: 0x96 arrives on the frame-end edge while 0xFF is held
    send(8'h00);
    fork
      begin
        expect_frame("lb 00", 10'b1000000000);
        @(posedge clk);
        #1;
      end
      begin
        repeat (4) @(posedge clk);
        #1;
        u_if.trmt    = 1'b1;
        u_if.tx_data = 8'hFF;
        @(posedge clk);
        #1;
        u_if.trmt = 1'b0;
        check("lb full@5", {31'd0, u_if.full}, 32'd1);
        repeat (154) @(posedge clk);
        #1;
        u_if.trmt    = 1'b1;
        u_if.tx_data = 8'h96;
        @(posedge clk);
        #1;
        u_if.trmt = 1'b0;
        check("lb full@160", {31'd0, u_if.full},    32'd1);
        check("lb done@160", {31'd0, u_if.tx_done}, 32'd0);
      end
    join
    expect_frame("lb ff", 10'b1111111110);
    @(posedge clk);
    #1;
    check("lb full@320", {31'd0, u_if.full}, 32'd0);
    expect_frame("lb 96", 10'b1100101100);
    @(posedge clk);
    #1;
    check_idle("lb end", 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
